dmem_port_arbiter: RTL and testbench
====================================

// Module: dmem_port_arbiter
// PURPOSE
//  Shares the single data-memory port between the pipeline MEM stage (core) and an external
//  loader/DMA port (ext). Sits between EX/MEM outputs and Data_Memory; drives core_stall to
//  freeze PC, IF/ID, ID/EX and EX/MEM while ext owns the port. Core has default priority;
//  ext runs bounded bursts. Memory is single-cycle: write on posedge, read combinational.
// PARAMETERS
//  AW          32  address width (byte address, word aligned)
//  DW          32  data width
//  MAX_BURST   4   max consecutive ext accesses before ext must yield to a pending core request
//  STARVE_LIM  8   ext wait cycles before ext is forced a slot (only with DMEM_ARB_STARVE_EN)
// PORTS
//  clk         in   1   clock, all state on posedge
//  rst         in   1   synchronous, active-high reset
//  core_req    in   1   MEM stage access (MemRead|MemWrite of EX/MEM)
//  core_we     in   1   1=write, 0=read
//  core_addr   in   AW  ALU result from EX/MEM
//  core_wdata  in   DW  store data from EX/MEM
//  core_rdata  out  DW  read data to MEM/WB (mem_rdata when core owns port, else 0)
//  core_stall  out  1   1 = hold pipeline registers and PC this cycle
//  ext_req     in   1   ext access request, held until ext_gnt
//  ext_we      in   1   1=write, 0=read
//  ext_addr    in   AW  ext address
//  ext_wdata   in   DW  ext write data
//  ext_gnt     out  1   ext access performed this cycle
//  ext_rdata   out  DW  registered read data for last granted ext read
//  ext_rvalid  out  1   1-cycle pulse, cycle after a granted ext read
//  mem_we,mem_re out 1  to Data_Memory MemWrite/MemRead
//  mem_addr    out  AW  to Data_Memory ALUresult
//  mem_wdata   out  DW  to Data_Memory MemWriteData
//  mem_rdata   in   DW  from Data_Memory MemReadData
// BEHAVIOUR
//  - Reset: state=IDLE, burst_cnt=0, wait_cnt=0, ext_rdata=0, ext_rvalid=0; all other outputs
//    are combinational from state and evaluate to 0 while rst=1 (mem_we=mem_re=0, no stall).
//  - States: IDLE, CORE, EXT. Owner for the current cycle is decided combinationally:
//    IDLE/CORE: core_req -> core owns; else ext_req -> ext owns (enter EXT); else none.
//    EXT: ext_req && burst_cnt<MAX_BURST -> ext keeps port; else (ext_req low or burst
//    exhausted) port returns to core if core_req, else to ext if ext_req restarting burst.
//  - Next state = owner of this cycle (IDLE if none). burst_cnt increments per ext grant,
//    clears on any non-ext cycle; burst_cnt saturates at MAX_BURST.
//  - core_stall = core_req && owner!=core. Core instruction is retried next cycle unchanged.
//  - ext_gnt = owner==ext; handshake completes on ext_req&&ext_gnt; ext changes inputs after.
//  - Mux: mem_* driven from owner's inputs; mem_we/mem_re both 0 when no owner.
//  - ext read: ext_rdata<=mem_rdata and ext_rvalid<=1 on the granted cycle's posedge.
//  - Simultaneous core_req & ext_req in IDLE/CORE: core wins; ext waits (wait_cnt++).
//  - Exhausted burst with core_req low: ext continues (new burst, burst_cnt restarts at 1).
//  - rst mid-burst: abandoned; no mem write in reset cycle; ext must re-request.
//  - ext_addr/core_addr not word aligned: passed through unchanged (Data_Memory's concern).
// CONFIGURATION
//  DMEM_ARB_STARVE_EN defined: wait_cnt counts cycles with ext_req && !ext_gnt, saturating;
//  when wait_cnt==STARVE_LIM ext owns next cycle regardless of core_req (core stalled),
//  wait_cnt clears on any ext grant. Not defined: wait_cnt absent, ext may starve while
//  core_req is continuously high.
// STRUCTURE
//  Package dmem_arb_pkg: state enum {IDLE,CORE,EXT} (2-bit), owner encoding, default
//  MAX_BURST/STARVE_LIM constants. Single sub-module: dmem_arb_fsm (state, burst_cnt,
//  wait_cnt, owner decode); top holds the address/data muxes and ext_rdata register.
// TESTING
//  1 core-only: core_req=1 lw addr 0x10, mem holds 0xDEADBEEF -> core_rdata=0xDEADBEEF same
//    cycle, core_stall=0, ext_gnt=0.
//  2 ext-only burst of 3 writes 0x0/0x4/0x8 -> ext_gnt high 3 cycles, mem_we=1 each, state
//    returns IDLE after ext_req drops.
//  3 contention: core_req and ext_req both high from IDLE -> core granted, ext_gnt=0,
//    core_stall=0; ext granted first cycle core_req falls.
//  4 burst limit: ext in burst, core_req rises at grant 2 -> ext gets grants 3,4, core_stall=1
//    for those 2 cycles, cycle 5 core owns.
//  5 ext read 0x20 holding 0x12345678 -> next cycle ext_rvalid=1, ext_rdata=0x12345678.
//  6 STARVE_EN, core_req held high, ext_req high -> after 8 wait cycles ext_gnt=1 one cycle,
//    core_stall=1 that cycle; without macro ext_gnt stays 0. rst mid-burst -> all outputs 0.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the data-memory port arbiter.
// Optional starvation guard is enabled by defining DMEM_ARB_STARVE_EN.
package dmem_arb_pkg;

    localparam int unsigned DEF_AW         = 32;
    localparam int unsigned DEF_DW         = 32;
    localparam int unsigned DEF_MAX_BURST  = 4;
    localparam int unsigned DEF_STARVE_LIM = 8;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StCore = 2'd1,
        StExt  = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        OwnNone = 2'd0,
        OwnCore = 2'd1,
        OwnExt  = 2'd2
    } owner_e;

    // The next state is simply whoever owns the port this cycle.
    function automatic state_e owner_to_state(owner_e own);
        state_e st;
        unique case (own)
            OwnCore: st = StCore;
            OwnExt:  st = StExt;
            default: st = StIdle;
        endcase
        return st;
    endfunction

endpackage

// File: rtl/dmem_port_arbiter_if.sv
// Bus bundle between pipeline MEM stage, external loader port and Data_Memory.
// slave = arbiter view, master = environment view.
interface dmem_port_arbiter_if
    import dmem_arb_pkg::*;
#(
    parameter int unsigned AW = DEF_AW,
    parameter int unsigned DW = DEF_DW
);
    logic          core_req;
    logic          core_we;
    logic [AW-1:0] core_addr;
    logic [DW-1:0] core_wdata;
    logic [DW-1:0] core_rdata;
    logic          core_stall;

    logic          ext_req;
    logic          ext_we;
    logic [AW-1:0] ext_addr;
    logic [DW-1:0] ext_wdata;
    logic          ext_gnt;
    logic [DW-1:0] ext_rdata;
    logic          ext_rvalid;

    logic          mem_we;
    logic          mem_re;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  core_req, core_we, core_addr, core_wdata,
        input  ext_req, ext_we, ext_addr, ext_wdata,
        input  mem_rdata,
        output core_rdata, core_stall,
        output ext_gnt, ext_rdata, ext_rvalid,
        output mem_we, mem_re, mem_addr, mem_wdata
    );

    modport master (
        output core_req, core_we, core_addr, core_wdata,
        output ext_req, ext_we, ext_addr, ext_wdata,
        output mem_rdata,
        input  core_rdata, core_stall,
        input  ext_gnt, ext_rdata, ext_rvalid,
        input  mem_we, mem_re, mem_addr, mem_wdata
    );

endinterface

// File: rtl/dmem_arb_fsm.sv
// Ownership FSM: decides per cycle whether core, ext or nobody drives the memory port.
// DMEM_ARB_STARVE_EN adds a wait counter that forces an ext slot after STARVE_LIM waits.
module dmem_arb_fsm
    import dmem_arb_pkg::*;
#(
    parameter int unsigned MAX_BURST  = DEF_MAX_BURST,
    parameter int unsigned STARVE_LIM = DEF_STARVE_LIM
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   core_req,
    input  logic   ext_req,
    output owner_e owner
);

    localparam int unsigned BW = $clog2(MAX_BURST + 1);

    state_e        state_q, state_d;
    logic [BW-1:0] burst_cnt_q, burst_cnt_d;
    logic          burst_left;
    logic          starved;

    assign burst_left = (burst_cnt_q < BW'(MAX_BURST));

`ifdef DMEM_ARB_STARVE_EN
    localparam int unsigned WW = $clog2(STARVE_LIM + 1);

    logic [WW-1:0] wait_cnt_q, wait_cnt_d;

    assign starved = ext_req && (wait_cnt_q == WW'(STARVE_LIM));

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (owner == OwnExt) begin
            wait_cnt_d = '0;
        end else if (ext_req && (wait_cnt_q != WW'(STARVE_LIM))) begin
            wait_cnt_d = wait_cnt_q + WW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end
`else
    assign starved = 1'b0;
`endif

    always_comb begin
        owner = OwnNone;
        if (rst) begin
            owner = OwnNone;
        end else if (starved) begin
            owner = OwnExt;
        end else if ((state_q == StExt) && ext_req && burst_left) begin
            owner = OwnExt;
        end else if (core_req) begin
            owner = OwnCore;
        end else if (ext_req) begin
            owner = OwnExt;
        end
    end

    always_comb begin
        state_d     = owner_to_state(owner);
        burst_cnt_d = '0;
        // An exhausted burst that ext keeps anyway starts a fresh one.
        if (owner == OwnExt) begin
            burst_cnt_d = burst_left ? burst_cnt_q + BW'(1) : BW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares the single Data_Memory port between the MEM stage and an external loader port.
// Define DMEM_ARB_STARVE_EN to bound how long ext can be locked out by the core.
module dmem_port_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned AW         = DEF_AW,
    parameter int unsigned DW         = DEF_DW,
    parameter int unsigned MAX_BURST  = DEF_MAX_BURST,
    parameter int unsigned STARVE_LIM = DEF_STARVE_LIM
) (
    input logic               clk,
    input logic               rst,
    dmem_port_arbiter_if.slave bus
);

    owner_e        owner;
    logic          we_mux;
    logic          re_mux;
    logic [AW-1:0] addr_mux;
    logic [DW-1:0] wdata_mux;
    logic [DW-1:0] core_rdata_mux;
    logic          ext_rd_grant;
    logic [DW-1:0] ext_rdata_q;
    logic          ext_rvalid_q;

    dmem_arb_fsm #(
        .MAX_BURST  (MAX_BURST),
        .STARVE_LIM (STARVE_LIM)
    ) u_fsm (
        .clk      (clk),
        .rst      (rst),
        .core_req (bus.core_req),
        .ext_req  (bus.ext_req),
        .owner    (owner)
    );

    always_comb begin
        we_mux         = 1'b0;
        re_mux         = 1'b0;
        addr_mux       = '0;
        wdata_mux      = '0;
        core_rdata_mux = '0;
        unique case (owner)
            OwnCore: begin
                we_mux         = bus.core_we;
                re_mux         = !bus.core_we;
                addr_mux       = bus.core_addr;
                wdata_mux      = bus.core_wdata;
                core_rdata_mux = bus.mem_rdata;
            end
            OwnExt: begin
                we_mux    = bus.ext_we;
                re_mux    = !bus.ext_we;
                addr_mux  = bus.ext_addr;
                wdata_mux = bus.ext_wdata;
            end
            default: ;
        endcase
    end

    assign bus.mem_we     = we_mux;
    assign bus.mem_re     = re_mux;
    assign bus.mem_addr   = addr_mux;
    assign bus.mem_wdata  = wdata_mux;
    assign bus.core_rdata = core_rdata_mux;
    assign bus.core_stall = !rst && bus.core_req && (owner != OwnCore);
    assign bus.ext_gnt    = (owner == OwnExt);

    assign ext_rd_grant = (owner == OwnExt) && !bus.ext_we;

    always_ff @(posedge clk) begin
        if (rst) begin
            ext_rdata_q  <= '0;
            ext_rvalid_q <= 1'b0;
        end else begin
            ext_rvalid_q <= ext_rd_grant;
            if (ext_rd_grant) begin
                ext_rdata_q <= bus.mem_rdata;
            end
        end
    end

    assign bus.ext_rdata  = ext_rdata_q;
    assign bus.ext_rvalid = ext_rvalid_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench for dmem_port_arbiter: directed vector table, corner sequences, and
// randomized traffic against a rule-level reference model (DMEM_ARB_STARVE_EN aware).
module tb_dmem_port_arbiter;

    localparam int unsigned AW   = 32;
    localparam int unsigned DW   = 32;
    localparam int          MAXB = 4;
    localparam int          LIM  = 8;
`ifdef DMEM_ARB_STARVE_EN
    localparam bit STARVE = 1'b1;
`else
    localparam bit STARVE = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dmem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    dmem_port_arbiter #(
        .AW         (AW),
        .DW         (DW),
        .MAX_BURST  (MAXB),
        .STARVE_LIM (LIM)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Data_Memory stand-in: combinational read, posedge write, plus a preload port.
    logic [31:0] mem [64];
    logic        ld_en;
    logic [5:0]  ld_idx;
    logic [31:0] ld_data;

    always @(posedge clk) begin
        if (ld_en) mem[ld_idx] <= ld_data;
        else if (bus.mem_we) mem[bus.mem_addr[7:2]] <= bus.mem_wdata;
    end
    assign bus.mem_rdata = mem[bus.mem_addr[7:2]];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model state: consecutive ext grants, ext wait cycles, pending ext read.
    int          m_run = 0;
    int          m_wait = 0;
    bit          m_prev_ext = 1'b0;
    bit          m_rv_exp = 1'b0;
    logic [31:0] m_rd_exp = '0;
    int          last_own = 0;

    logic        s_stall, s_gnt, s_we, s_re, s_rvalid;
    logic [31:0] s_rdata, s_erdata;

    task automatic drive(input logic r, input logic cq, input logic cw, input logic [31:0] ca,
                         input logic [31:0] cd, input logic eq, input logic ew,
                         input logic [31:0] ea, input logic [31:0] ed);
        rst            = r;
        bus.core_req   = cq;
        bus.core_we    = cw;
        bus.core_addr  = ca;
        bus.core_wdata = cd;
        bus.ext_req    = eq;
        bus.ext_we     = ew;
        bus.ext_addr   = ea;
        bus.ext_wdata  = ed;
    endtask

    // One clock: compare against the model mid-cycle, then advance the model at the edge.
    task automatic cycle();
        int          own;
        bit          nxt_rv;
        logic [31:0] nxt_rd, exp_addr, exp_wd;
        logic        exp_we;
        @(negedge clk);
        if (rst) own = 0;
        else if (STARVE && bus.ext_req && m_wait == LIM) own = 2;
        else if (m_prev_ext && bus.ext_req && m_run < MAXB) own = 2;
        else if (bus.core_req) own = 1;
        else if (bus.ext_req) own = 2;
        else own = 0;

        s_stall  = bus.core_stall;
        s_gnt    = bus.ext_gnt;
        s_we     = bus.mem_we;
        s_re     = bus.mem_re;
        s_rdata  = bus.core_rdata;
        s_rvalid = bus.ext_rvalid;
        s_erdata = bus.ext_rdata;

        exp_we   = (own == 1) ? bus.core_we : bus.ext_we;
        exp_addr = (own == 1) ? bus.core_addr : bus.ext_addr;
        exp_wd   = (own == 1) ? bus.core_wdata : bus.ext_wdata;

        chk("m_core_stall", s_stall, !rst && bus.core_req && own != 1);
        chk("m_ext_gnt", s_gnt, own == 2);
        chk("m_mem_we", s_we, own != 0 && exp_we);
        chk("m_mem_re", s_re, own != 0 && !exp_we);
        if (own != 0) begin
            chk("m_mem_addr", bus.mem_addr, exp_addr);
            chk("m_mem_wdata", bus.mem_wdata, exp_wd);
        end
        chk("m_core_rdata", s_rdata, (own == 1) ? mem[exp_addr[7:2]] : 32'h0);
        chk("m_ext_rvalid", s_rvalid, m_rv_exp);
        if (m_rv_exp) chk("m_ext_rdata", s_erdata, m_rd_exp);

        nxt_rv = (own == 2) && !bus.ext_we;
        nxt_rd = mem[bus.ext_addr[7:2]];

        @(posedge clk);
        if (rst) begin
            m_run = 0; m_wait = 0; m_prev_ext = 1'b0; m_rv_exp = 1'b0; m_rd_exp = '0;
        end else begin
            m_rv_exp = nxt_rv;
            if (nxt_rv) m_rd_exp = nxt_rd;
            if (own == 2) m_run = (m_run >= MAXB) ? 1 : m_run + 1;
            else m_run = 0;
            if (own == 2) m_wait = 0;
            else if (bus.ext_req && m_wait < LIM) m_wait = m_wait + 1;
            m_prev_ext = (own == 2);
        end
        last_own = own;
        #1;
    endtask

    typedef struct {
        logic        rst, creq, cwe;
        logic [31:0] caddr, cwd;
        logic        ereq, ewe;
        logic [31:0] eaddr, ewd;
        logic        stall, gnt, mwe, mre;
        logic [31:0] crd;
        logic        rv;
        logic [31:0] erd;
    } vec_t;

    function automatic vec_t mk(logic r, logic cq, logic cw, logic [31:0] ca, logic [31:0] cd,
                                logic eq, logic ew, logic [31:0] ea, logic [31:0] ed,
                                logic st, logic g, logic mw, logic mr, logic [31:0] crd,
                                logic rv, logic [31:0] erd);
        vec_t v;
        v.rst = r;   v.creq = cq; v.cwe = cw; v.caddr = ca; v.cwd = cd;
        v.ereq = eq; v.ewe = ew;  v.eaddr = ea; v.ewd = ed;
        v.stall = st; v.gnt = g;  v.mwe = mw; v.mre = mr; v.crd = crd;
        v.rv = rv;   v.erd = erd;
        return v;
    endfunction

    function automatic logic [31:0] rnd_addr();
        int r;
        r = $urandom_range(0, 255);
        if ($urandom_range(0, 7) != 0) r = r & 'hFC;
        return 32'(r);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[13];

        ld_en = 1'b0; ld_idx = '0; ld_data = '0;
        drive(1'b1, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        for (int i = 0; i < 64; i++) begin
            ld_en   = 1'b1;
            ld_idx  = i[5:0];
            ld_data = (i == 4) ? 32'hDEAD_BEEF : (i == 8) ? 32'h1234_5678 : 32'(i) * 32'h0101_0101;
            @(posedge clk); #1;
        end
        ld_en = 1'b0;

        // Reset with both requesters active: nothing may reach the memory.
        drive(1'b1, 1, 1, 32'h10, 32'h99, 1, 1, 32'h14, 32'h77);
        cycle();
        chk("rst_stall", s_stall, 1'b0);
        chk("rst_gnt", s_gnt, 1'b0);
        chk("rst_mem_we", s_we, 1'b0);
        chk("rst_rvalid", s_rvalid, 1'b0);

        //             rst cq cw addr      wdata         eq ew addr      wdata
        //             st  g  mw mr crd            rv erd
        tbl[0]  = mk(0, 1, 0, 32'h10, 32'h0,         0, 0, 32'h0,  32'h0,
                     0, 0, 0, 1, 32'hDEAD_BEEF, 0, 32'h0);
        tbl[1]  = mk(0, 0, 0, 32'h0,  32'h0,         0, 0, 32'h0,  32'h0,
                     0, 0, 0, 0, 32'h0,         0, 32'h0);
        tbl[2]  = mk(0, 0, 0, 32'h0,  32'h0,         1, 1, 32'h0,  32'h1111_1111,
                     0, 1, 1, 0, 32'h0,         0, 32'h0);
        tbl[3]  = mk(0, 0, 0, 32'h0,  32'h0,         1, 1, 32'h4,  32'h2222_2222,
                     0, 1, 1, 0, 32'h0,         0, 32'h0);
        tbl[4]  = mk(0, 0, 0, 32'h0,  32'h0,         1, 1, 32'h8,  32'h3333_3333,
                     0, 1, 1, 0, 32'h0,         0, 32'h0);
        tbl[5]  = mk(0, 0, 0, 32'h0,  32'h0,         0, 0, 32'h0,  32'h0,
                     0, 0, 0, 0, 32'h0,         0, 32'h0);
        tbl[6]  = mk(0, 1, 0, 32'h0,  32'h0,         0, 0, 32'h0,  32'h0,
                     0, 0, 0, 1, 32'h1111_1111, 0, 32'h0);
        tbl[7]  = mk(0, 1, 1, 32'h30, 32'hAAAA_0000, 1, 0, 32'h20, 32'h0,
                     0, 0, 1, 0, 32'h0C0C_0C0C, 0, 32'h0);
        tbl[8]  = mk(0, 0, 0, 32'h0,  32'h0,         1, 0, 32'h20, 32'h0,
                     0, 1, 0, 1, 32'h0,         0, 32'h0);
        tbl[9]  = mk(0, 0, 0, 32'h0,  32'h0,         0, 0, 32'h0,  32'h0,
                     0, 0, 0, 0, 32'h0,         1, 32'h1234_5678);
        tbl[10] = mk(1, 1, 0, 32'h10, 32'h0,         1, 1, 32'h4,  32'hFFFF_FFFF,
                     0, 0, 0, 0, 32'h0,         0, 32'h0);
        tbl[11] = mk(0, 1, 0, 32'h8,  32'h0,         0, 0, 32'h0,  32'h0,
                     0, 0, 0, 1, 32'h3333_3333, 0, 32'h0);
        tbl[12] = mk(0, 1, 0, 32'h30, 32'h0,         0, 0, 32'h0,  32'h0,
                     0, 0, 0, 1, 32'hAAAA_0000, 0, 32'h0);

        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].creq, tbl[i].cwe, tbl[i].caddr, tbl[i].cwd,
                  tbl[i].ereq, tbl[i].ewe, tbl[i].eaddr, tbl[i].ewd);
            cycle();
            chk($sformatf("v%0d_stall", i), s_stall, tbl[i].stall);
            chk($sformatf("v%0d_gnt", i), s_gnt, tbl[i].gnt);
            chk($sformatf("v%0d_mem_we", i), s_we, tbl[i].mwe);
            chk($sformatf("v%0d_mem_re", i), s_re, tbl[i].mre);
            chk($sformatf("v%0d_core_rdata", i), s_rdata, tbl[i].crd);
            chk($sformatf("v%0d_rvalid", i), s_rvalid, tbl[i].rv);
            if (tbl[i].rv) chk($sformatf("v%0d_ext_rdata", i), s_erdata, tbl[i].erd);
        end

        // Burst limit: core arrives after grant 2, ext finishes grants 3 and 4 first.
        for (int g = 0; g < 5; g++) begin
            drive(0, g >= 2, 0, 32'h10, 0, 1, 1, 32'h40 + 32'(4 * g), 32'hB000 + 32'(g));
            cycle();
            if (g < 4) begin
                chk($sformatf("burst_g%0d_gnt", g + 1), s_gnt, 1'b1);
                chk($sformatf("burst_g%0d_stall", g + 1), s_stall, g >= 2);
            end else begin
                chk("burst_core_gnt", s_gnt, 1'b0);
                chk("burst_core_stall", s_stall, 1'b0);
                chk("burst_core_rdata", s_rdata, 32'hDEAD_BEEF);
            end
        end
        drive(0, 0, 0, 0, 0, 1, 1, 32'h50, 32'hB004);
        cycle();
        chk("burst_ext_resume", s_gnt, 1'b1);

        // Reset in the middle of a burst abandons it; ext re-requests afterwards.
        drive(0, 0, 0, 0, 0, 1, 1, 32'h70, 32'hC0);
        cycle();
        drive(1, 0, 0, 0, 0, 1, 1, 32'h74, 32'hC1);
        cycle();
        chk("midrst_gnt", s_gnt, 1'b0);
        chk("midrst_mem_we", s_we, 1'b0);
        drive(0, 0, 0, 0, 0, 1, 1, 32'h74, 32'hC1);
        cycle();
        chk("midrst_regrant", s_gnt, 1'b1);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle();

        // Core holds the port; ext is only forced in when the starvation guard is built in.
        drive(0, 1, 0, 32'h10, 0, 1, 1, 32'h60, 32'h5A5A);
        for (int i = 0; i <= LIM; i++) begin
            cycle();
            chk($sformatf("starve_%0d_gnt", i), s_gnt, STARVE && i == LIM);
            chk($sformatf("starve_%0d_stall", i), s_stall, STARVE && i == LIM);
            if (s_gnt) break;
        end
        if (!STARVE) begin
            drive(0, 0, 0, 32'h10, 0, 1, 1, 32'h60, 32'h5A5A);
            cycle();
            chk("starve_release_gnt", s_gnt, 1'b1);
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle();

        // Random traffic: stalled core and ungranted ext keep their requests unchanged.
        for (int n = 0; n < 800; n++) begin
            logic        r, cq, cw, eq, ew;
            logic [31:0] ca, cd, ea, ed;
            r  = ($urandom_range(0, 63) == 0);
            cq = bus.core_req; cw = bus.core_we; ca = bus.core_addr; cd = bus.core_wdata;
            eq = bus.ext_req;  ew = bus.ext_we;  ea = bus.ext_addr;  ed = bus.ext_wdata;
            if (!(bus.core_req && last_own != 1)) begin
                cq = ($urandom_range(0, 9) < 6);
                cw = $urandom_range(0, 1) == 1;
                ca = rnd_addr();
                cd = $urandom;
            end
            if (!(bus.ext_req && last_own != 2)) begin
                eq = ($urandom_range(0, 9) < 5);
                ew = $urandom_range(0, 1) == 1;
                ea = rnd_addr();
                ed = $urandom;
            end
            drive(r, cq, cw, ca, cd, eq, ew, ea, ed);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
